// File: rtl/rotary_decoder.sv
// Quadrature rotary encoder front end: synchronizes and debounces both channels,
// then tracks detents with a Gray-sequence FSM that produces step pulses, a position count and error pulses.
module rotary_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ROT_A,
    input  logic       ROT_B,
    output logic       step_cw,
    output logic       step_ccw,
    output logic [7:0] pos,
    output logic       err,
    output logic       a_db,
    output logic       b_db
);

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned POS_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CW1    = 3'd1,
        CW2    = 3'd2,
        CW3    = 3'd3,
        CCW1   = 3'd4,
        CCW2   = 3'd5,
        CCW3   = 3'd6,
        RESYNC = 3'd7
    } state_t;

    // Bit 1 carries channel A, bit 0 carries channel B throughout.
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] stable;
    logic [1:0]        ab;

    state_t state;
    state_t state_nxt;
    logic   cw_c;
    logic   ccw_c;
    logic   err_c;

    // Two-flop synchronizer; reset to the idle-high level of the encoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {ROT_A, ROT_B};
            sync2 <= sync1;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             level;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                level <= 1'b1;
            end else if (sync2[i] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2[i];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign stable[i] = level;
    end

    assign a_db = stable[1];
    assign b_db = stable[0];
    assign ab   = stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each state owns one expected code; one-bit moves step forward/back, two-bit moves are illegal.
    always_comb begin
        state_nxt = state;
        cw_c      = 1'b0;
        ccw_c     = 1'b0;
        err_c     = 1'b0;
        case (state)
            IDLE: begin
                case (ab)
                    2'b10:   state_nxt = CW1;
                    2'b01:   state_nxt = CCW1;
                    2'b00:   begin state_nxt = RESYNC; err_c = 1'b1; end
                    default: state_nxt = IDLE;
                endcase
            end
            CW1: begin
                case (ab)
                    2'b00:   state_nxt = CW2;
                    2'b11:   state_nxt = IDLE;
                    2'b01:   begin state_nxt = RESYNC; err_c = 1'b1; end
                    default: state_nxt = CW1;
                endcase
            end
            CW2: begin
                case (ab)
                    2'b01:   state_nxt = CW3;
                    2'b10:   state_nxt = CW1;
                    2'b11:   begin state_nxt = RESYNC; err_c = 1'b1; end
                    default: state_nxt = CW2;
                endcase
            end
            CW3: begin
                case (ab)
                    2'b11:   begin state_nxt = IDLE; cw_c = 1'b1; end
                    2'b00:   state_nxt = CW2;
                    2'b10:   begin state_nxt = RESYNC; err_c = 1'b1; end
                    default: state_nxt = CW3;
                endcase
            end
            CCW1: begin
                case (ab)
                    2'b00:   state_nxt = CCW2;
                    2'b11:   state_nxt = IDLE;
                    2'b10:   begin state_nxt = RESYNC; err_c = 1'b1; end
                    default: state_nxt = CCW1;
                endcase
            end
            CCW2: begin
                case (ab)
                    2'b10:   state_nxt = CCW3;
                    2'b01:   state_nxt = CCW1;
                    2'b11:   begin state_nxt = RESYNC; err_c = 1'b1; end
                    default: state_nxt = CCW2;
                endcase
            end
            CCW3: begin
                case (ab)
                    2'b11:   begin state_nxt = IDLE; ccw_c = 1'b1; end
                    2'b00:   state_nxt = CCW2;
                    2'b01:   begin state_nxt = RESYNC; err_c = 1'b1; end
                    default: state_nxt = CCW3;
                endcase
            end
            RESYNC: begin
                if (ab == 2'b11) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pulses and position update on the same edge, so pos is current while a pulse is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cw  <= 1'b0;
            step_ccw <= 1'b0;
            err      <= 1'b0;
            pos      <= '0;
        end else begin
            step_cw  <= cw_c;
            step_ccw <= ccw_c;
            err      <= err_c;
            if (cw_c) begin
                pos <= pos + POS_W'(1);
            end else if (ccw_c) begin
                pos <= pos - POS_W'(1);
            end
        end
    end

endmodule
